// File: rtl/dm.sv
// Shared debug-module types for the DMI path between the JTAG DTM and the debug module.
package dm;

  localparam int unsigned DmiOpWidth   = 2;
  localparam int unsigned DmiAddrWidth = 7;
  localparam int unsigned DmiDataWidth = 32;

  typedef enum logic [1:0] {
    DtmNop   = 2'd0,
    DtmRead  = 2'd1,
    DtmWrite = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DmiNoError = 2'd0,
    DmiFailed  = 2'd2,
    DmiBusy    = 2'd3
  } dmi_error_e;

  typedef struct packed {
    logic [DmiAddrWidth-1:0] addr;
    dtm_op_e                 op;
    logic [DmiDataWidth-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataWidth-1:0] data;
    logic [1:0]              resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_dr_ctrl.sv
// DMIACCESS data register and DMI transaction controller in the TCK domain.
// Shifts {address, data, op}, launches DMI requests on update and tracks sticky dmistat.
module dmi_jtag_dr_ctrl
  import dm::*;
#(
  parameter int unsigned AddrWidth = DmiAddrWidth,
  parameter int unsigned DataWidth = DmiDataWidth
) (
  input  logic      tck_i,
  input  logic      trst_ni,
  input  logic      test_logic_reset_i,
  input  logic      dmi_access_i,
  input  logic      capture_dr_i,
  input  logic      shift_dr_i,
  input  logic      update_dr_i,
  input  logic      dmi_reset_i,
  input  logic      tdi_i,
  output logic      tdo_o,
  output logic [1:0] dmi_error_o,
  output logic      dmi_req_valid_o,
  input  logic      dmi_req_ready_i,
  output dmi_req_t  dmi_req_o,
  input  logic      dmi_resp_valid_i,
  output logic      dmi_resp_ready_o,
  input  dmi_resp_t dmi_resp_i
);

  localparam int unsigned DrWidth = AddrWidth + DataWidth + DmiOpWidth;

  typedef enum logic [2:0] {
    Idle,
    Read,
    WaitRead,
    Write,
    WaitWrite
  } state_e;

  state_e                 state_q, state_d;
  logic [DrWidth-1:0]     dr_q, dr_d;
  logic [AddrWidth-1:0]   address_q, address_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [1:0]             error_q, error_d;

  logic capture_fire, shift_fire, update_fire, resp_fire;

  assign capture_fire = dmi_access_i & capture_dr_i;
  assign shift_fire   = dmi_access_i & shift_dr_i;
  assign update_fire  = dmi_access_i & update_dr_i;
  assign resp_fire    = dmi_resp_ready_o & dmi_resp_valid_i;

  // A new transaction only starts from Idle with no pending sticky error.
  always_comb begin
    state_d          = state_q;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    unique case (state_q)
      Idle: begin
        if (update_fire && (error_q == 2'(DmiNoError))) begin
          if (dr_q[1:0] == 2'(DtmRead)) begin
            state_d = Read;
          end else if (dr_q[1:0] == 2'(DtmWrite)) begin
            state_d = Write;
          end
        end
      end
      Read: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) state_d = WaitRead;
      end
      Write: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) state_d = WaitWrite;
      end
      WaitRead, WaitWrite: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // The dmireset clear comes first so a busy/failed event in the same cycle wins.
  always_comb begin
    dr_d      = dr_q;
    address_d = address_q;
    data_d    = data_q;
    error_d   = error_q;

    if (dmi_reset_i) error_d = 2'(DmiNoError);

    if (capture_fire) begin
      dr_d = {address_q, data_q, error_q};
      if (state_q != Idle) begin
        dr_d[1:0] = 2'(DmiBusy);
        error_d   = 2'(DmiBusy);
      end
    end else if (shift_fire) begin
      dr_d = {tdi_i, dr_q[DrWidth-1:1]};
    end else if (update_fire && (error_q == 2'(DmiNoError))) begin
      if (state_q != Idle) begin
        error_d = 2'(DmiBusy);
      end else begin
        address_d = dr_q[DrWidth-1 -: AddrWidth];
        data_d    = dr_q[DmiOpWidth +: DataWidth];
      end
    end

    if (resp_fire) begin
      if (state_q == WaitRead) data_d = dmi_resp_i.data;
      if (dmi_resp_i.resp != 2'(DmiNoError)) error_d = dmi_resp_i.resp;
    end

    if (test_logic_reset_i) begin
      dr_d      = '0;
      address_d = '0;
      data_d    = '0;
      error_d   = 2'(DmiNoError);
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= Idle;
      dr_q      <= '0;
      address_q <= '0;
      data_q    <= '0;
      error_q   <= 2'(DmiNoError);
    end else begin
      state_q   <= state_d;
      dr_q      <= dr_d;
      address_q <= address_d;
      data_q    <= data_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    dmi_req_o      = '0;
    dmi_req_o.addr = address_q;
    dmi_req_o.data = data_q;
    if (state_q == Read || state_q == WaitRead) begin
      dmi_req_o.op = DtmRead;
    end else if (state_q == Write || state_q == WaitWrite) begin
      dmi_req_o.op = DtmWrite;
    end else begin
      dmi_req_o.op = DtmNop;
    end
  end

  assign tdo_o       = dr_q[0];
  assign dmi_error_o = error_q;

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Directed scoreboard bench for dmi_jtag_dr_ctrl: DR scans, DMI handshakes, busy/failed errors, resets.
module tb_dmi_jtag_dr_ctrl;
  import dm::*;

  localparam int DrW = 41;

  logic      tck = 1'b0;
  logic      trst_ni, test_logic_reset, dmi_access, capture_dr, shift_dr, update_dr;
  logic      dmi_reset, tdi, tdo, dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [1:0] dmi_error;
  dmi_req_t  dmi_req;
  dmi_resp_t dmi_resp;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [DrW-1:0] exp_dr_q[$];
  logic [DrW-1:0] exp_req_q[$];

  dmi_jtag_dr_ctrl dut (
    .tck_i              (tck),
    .trst_ni            (trst_ni),
    .test_logic_reset_i (test_logic_reset),
    .dmi_access_i       (dmi_access),
    .capture_dr_i       (capture_dr),
    .shift_dr_i         (shift_dr),
    .update_dr_i        (update_dr),
    .dmi_reset_i        (dmi_reset),
    .tdi_i              (tdi),
    .tdo_o              (tdo),
    .dmi_error_o        (dmi_error),
    .dmi_req_valid_o    (dmi_req_valid),
    .dmi_req_ready_i    (dmi_req_ready),
    .dmi_req_o          (dmi_req),
    .dmi_resp_valid_i   (dmi_resp_valid),
    .dmi_resp_ready_o   (dmi_resp_ready),
    .dmi_resp_i         (dmi_resp)
  );

  always #5 tck = ~tck;

  function automatic logic [DrW-1:0] mk_dr(logic [6:0] a, logic [31:0] d, logic [1:0] op);
    return {a, d, op};
  endfunction

  function automatic logic [DrW-1:0] mk_req(logic [6:0] a, logic [1:0] op, logic [31:0] d);
    return {a, op, d};
  endfunction

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatch++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle strobe of the TAP inputs; access returns to 1 afterwards.
  task automatic applyStimulus(input logic cap, input logic upd, input logic acc);
    capture_dr = cap;
    update_dr  = upd;
    dmi_access = acc;
    tick();
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    dmi_access = 1'b1;
  endtask

  task automatic scan(input logic [DrW-1:0] din, input logic acc, input logic do_cap,
                      output logic [DrW-1:0] dout);
    if (do_cap) applyStimulus(1'b1, 1'b0, acc);
    for (int i = 0; i < DrW; i++) begin
      shift_dr   = 1'b1;
      dmi_access = acc;
      tdi        = din[i];
      dout[i]    = tdo;
      tick();
    end
    shift_dr   = 1'b0;
    tdi        = 1'b0;
    dmi_access = 1'b1;
  endtask

  task automatic capture_scan(input string tag, input logic [DrW-1:0] expv, input logic [DrW-1:0] din);
    logic [DrW-1:0] dout;
    exp_dr_q.push_back(expv);
    scan(din, 1'b1, 1'b1, dout);
    checkOutput(tag, 64'(dout), 64'(exp_dr_q.pop_front()));
  endtask

  task automatic load_and_update(input logic [DrW-1:0] din, input logic expect_req,
                                 input logic [DrW-1:0] req);
    logic [DrW-1:0] dout;
    scan(din, 1'b1, 1'b0, dout);
    if (expect_req) exp_req_q.push_back(req);
    applyStimulus(1'b0, 1'b1, 1'b1);
  endtask

  task automatic check_req(input string tag);
    checkOutput({tag, "_valid"}, 64'(dmi_req_valid), 64'd1);
    if (exp_req_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      checkOutput({tag, "_req"}, 64'(dmi_req), 64'(exp_req_q.pop_front()));
    end
  endtask

  task automatic accept_req();
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_valid = 1'b1;
    dmi_resp.data  = data;
    dmi_resp.resp  = resp;
    tick();
    dmi_resp_valid = 1'b0;
    dmi_resp       = '0;
  endtask

  initial begin
    logic [DrW-1:0] dout;
    logic [DrW-1:0] held;
    trst_ni = 1'b0;
    test_logic_reset = 1'b0;
    dmi_access = 1'b1;
    capture_dr = 1'b0;
    shift_dr = 1'b0;
    update_dr = 1'b0;
    dmi_reset = 1'b0;
    tdi = 1'b0;
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp = '0;

    #12;
    checkOutput("rst_valid", 64'(dmi_req_valid), 64'd0);
    checkOutput("rst_error", 64'(dmi_error), 64'd0);
    checkOutput("rst_req", 64'(dmi_req), 64'd0);
    checkOutput("rst_tdo", 64'(tdo), 64'd0);
    @(negedge tck);
    trst_ni = 1'b1;
    tick();

    $display("[TB] write transaction");
    load_and_update(mk_dr(7'h10, 32'h8000_0001, 2'd2), 1'b1, mk_req(7'h10, 2'd2, 32'h8000_0001));
    held = mk_req(7'h10, 2'd2, 32'h8000_0001);
    check_req("wr");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wr_hold_valid", 64'(dmi_req_valid), 64'd1);
      checkOutput("wr_hold_req", 64'(dmi_req), 64'(held));
    end
    accept_req();
    checkOutput("wr_wait_valid", 64'(dmi_req_valid), 64'd0);
    checkOutput("wr_wait_rready", 64'(dmi_resp_ready), 64'd1);
    respond(32'h0, 2'd0);
    checkOutput("wr_idle_rready", 64'(dmi_resp_ready), 64'd0);
    checkOutput("wr_error", 64'(dmi_error), 64'd0);
    capture_scan("wr_capture", mk_dr(7'h10, 32'h8000_0001, 2'd0), '0);

    $display("[TB] read transaction");
    load_and_update(mk_dr(7'h11, 32'h0, 2'd1), 1'b1, mk_req(7'h11, 2'd1, 32'h0));
    check_req("rd");
    accept_req();
    respond(32'hDEAD_BEEF, 2'd0);
    capture_scan("rd_capture", mk_dr(7'h11, 32'hDEAD_BEEF, 2'd0), '0);

    $display("[TB] busy");
    load_and_update(mk_dr(7'h12, 32'h0, 2'd1), 1'b1, mk_req(7'h12, 2'd1, 32'h0));
    check_req("busy_rd");
    accept_req();
    capture_scan("busy_capture", mk_dr(7'h12, 32'h0, 2'd3), mk_dr(7'h13, 32'h0, 2'd2));
    checkOutput("busy_error", 64'(dmi_error), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("busy_upd_novalid", 64'(dmi_req_valid), 64'd0);
    checkOutput("busy_still_wait", 64'(dmi_resp_ready), 64'd1);
    respond(32'h55, 2'd0);
    checkOutput("busy_sticky", 64'(dmi_error), 64'd3);
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
    checkOutput("busy_cleared", 64'(dmi_error), 64'd0);

    $display("[TB] failed");
    load_and_update(mk_dr(7'h14, 32'h0, 2'd1), 1'b1, mk_req(7'h14, 2'd1, 32'h0));
    check_req("fail_rd");
    accept_req();
    respond(32'h77, 2'd2);
    checkOutput("fail_error", 64'(dmi_error), 64'd2);
    capture_scan("fail_capture", mk_dr(7'h14, 32'h77, 2'd2), mk_dr(7'h15, 32'h0, 2'd1));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("fail_upd_novalid", 64'(dmi_req_valid), 64'd0);
    tick();
    checkOutput("fail_upd_novalid2", 64'(dmi_req_valid), 64'd0);
    checkOutput("fail_sticky", 64'(dmi_error), 64'd2);
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;

    $display("[TB] test-logic-reset");
    load_and_update(mk_dr(7'h16, 32'h0, 2'd1), 1'b1, mk_req(7'h16, 2'd1, 32'h0));
    check_req("tlr_rd");
    accept_req();
    capture_scan("tlr_busy_capture", mk_dr(7'h16, 32'h0, 2'd3), mk_dr(7'h7F, 32'hFFFF_FFFF, 2'd3));
    checkOutput("tlr_pre_error", 64'(dmi_error), 64'd3);
    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    checkOutput("tlr_error", 64'(dmi_error), 64'd0);
    checkOutput("tlr_fsm_kept", 64'(dmi_resp_ready), 64'd1);
    scan('0, 1'b1, 1'b0, dout);
    checkOutput("tlr_dr_zero", 64'(dout), 64'd0);
    respond(32'h99, 2'd0);
    capture_scan("tlr_capture", mk_dr(7'h00, 32'h99, 2'd0), '0);

    $display("[TB] isolation");
    load_and_update(mk_dr(7'h20, 32'h1234, 2'd0), 1'b0, '0);
    checkOutput("iso_nop_novalid", 64'(dmi_req_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    scan({DrW{1'b1}}, 1'b0, 1'b0, dout);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("iso_novalid", 64'(dmi_req_valid), 64'd0);
    checkOutput("iso_error", 64'(dmi_error), 64'd0);
    scan('0, 1'b1, 1'b0, dout);
    checkOutput("iso_dr_kept", 64'(dout), 64'(mk_dr(7'h20, 32'h1234, 2'd0)));

    $display("[TB] async reset in WaitWrite");
    load_and_update(mk_dr(7'h30, 32'hA5A5, 2'd2), 1'b1, mk_req(7'h30, 2'd2, 32'hA5A5));
    check_req("arst_wr");
    accept_req();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("arst_pre_error", 64'(dmi_error), 64'd3);
    checkOutput("arst_pre_tdo", 64'(tdo), 64'd1);
    #2;
    trst_ni = 1'b0;
    #1;
    checkOutput("arst_rready", 64'(dmi_resp_ready), 64'd0);
    checkOutput("arst_valid", 64'(dmi_req_valid), 64'd0);
    checkOutput("arst_error", 64'(dmi_error), 64'd0);
    checkOutput("arst_req", 64'(dmi_req), 64'd0);
    checkOutput("arst_tdo", 64'(tdo), 64'd0);
    checkOutput("sb_req_drained", 64'(exp_req_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
